// File: rtl/nf_op_scheduler.sv
// nf_op_scheduler: sequences NAND flash read/write/erase operations.
// Latches request pulses, arbitrates one pending op, issues a single start
// pulse, then tracks ctrl_state and R/B# until completion, no-ack or timeout.
// Optional build macro NF_SCHED_RR_EN: round-robin arbitration instead of
// fixed erase > write > read priority.
// ACK_WAIT must be at least 2 and GAP at least 1.
module nf_op_scheduler #(
    parameter int ACK_WAIT = 16,
    parameter int TO_W     = 24,
    parameter int TO_MAX   = 2400000,
    parameter int GAP      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_r,
    input  logic        req_w,
    input  logic        req_e,
    input  logic        abort,
    input  logic [4:0]  ctrl_state,
    input  logic        ready_busy,
    output logic        start_r,
    output logic        start_w,
    output logic        start_e,
    output logic        busy,
    output logic [1:0]  grant,
    output logic [2:0]  pending,
    output logic        done,
    output logic        err_noack,
    output logic        err_timeout,
    output logic [15:0] op_cnt
);

    localparam int AW = $clog2(ACK_WAIT + 1);
    localparam int CW = $clog2(GAP + 1);
    // The no-ack pulse is registered, so the decision is taken one cycle
    // early to land it exactly ACK_WAIT cycles after the start pulse.
    localparam logic [AW-1:0]   ACK_LAST  = AW'(ACK_WAIT - 2);
    localparam logic [CW-1:0]   COOL_LAST = CW'(GAP - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_COOL
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      pending_q, pending_d;
    logic [1:0]      grant_q, grant_d;
    logic            start_r_q, start_r_d;
    logic            start_w_q, start_w_d;
    logic            start_e_q, start_e_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_noack_q, err_noack_d;
    logic            err_timeout_q, err_timeout_d;
    logic [15:0]     op_cnt_q, op_cnt_d;
    logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [CW-1:0]   cool_cnt_q, cool_cnt_d;
    logic            done_seen_q, done_seen_d;
    logic            rb_meta_q, rb_s_q;
    logic [1:0]      sel;
    logic [2:0]      clr_mask;
    logic            cmpl_cond;
`ifdef NF_SCHED_RR_EN
    logic [1:0]      last_q, last_d;
`endif

    // Arbitration: pick the grant code (1 read, 2 write, 3 erase) from pending.
    always_comb begin
        sel = 2'd0;
`ifdef NF_SCHED_RR_EN
        case (last_q)
            2'd1: begin
                if (pending_q[1])      sel = 2'd2;
                else if (pending_q[2]) sel = 2'd3;
                else if (pending_q[0]) sel = 2'd1;
            end
            2'd2: begin
                if (pending_q[2])      sel = 2'd3;
                else if (pending_q[0]) sel = 2'd1;
                else if (pending_q[1]) sel = 2'd2;
            end
            default: begin
                if (pending_q[0])      sel = 2'd1;
                else if (pending_q[1]) sel = 2'd2;
                else if (pending_q[2]) sel = 2'd3;
            end
        endcase
`else
        if (pending_q[2])      sel = 2'd3;
        else if (pending_q[1]) sel = 2'd2;
        else if (pending_q[0]) sel = 2'd1;
`endif
    end

    // Next-state, counters and registered outputs for the scheduler FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        start_r_d     = 1'b0;
        start_w_d     = 1'b0;
        start_e_d     = 1'b0;
        done_d        = 1'b0;
        err_noack_d   = 1'b0;
        err_timeout_d = 1'b0;
        op_cnt_d      = op_cnt_q;
        ack_cnt_d     = ack_cnt_q;
        to_cnt_d      = to_cnt_q;
        cool_cnt_d    = cool_cnt_q;
        done_seen_d   = done_seen_q;
        clr_mask      = 3'b000;
        cmpl_cond     = (ctrl_state == 5'd0) && rb_s_q;
`ifdef NF_SCHED_RR_EN
        last_d        = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pending_q != 3'b000) state_d = S_ARB;
            end
            S_ARB: begin
                grant_d   = sel;
                start_r_d = (sel == 2'd1);
                start_w_d = (sel == 2'd2);
                start_e_d = (sel == 2'd3);
                case (sel)
                    2'd1:    clr_mask = 3'b001;
                    2'd2:    clr_mask = 3'b010;
                    2'd3:    clr_mask = 3'b100;
                    default: clr_mask = 3'b000;
                endcase
`ifdef NF_SCHED_RR_EN
                last_d = sel;
`endif
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                ack_cnt_d = '0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                done_seen_d = 1'b0;
                if (ctrl_state != 5'd0) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    err_noack_d = 1'b1;
                    grant_d     = 2'd0;
                    cool_cnt_d  = '0;
                    state_d     = S_COOL;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            S_WAIT_DONE: begin
                to_cnt_d    = to_cnt_q + TO_W'(1);
                done_seen_d = cmpl_cond;
                if (cmpl_cond && done_seen_q) begin
                    done_d     = 1'b1;
                    op_cnt_d   = op_cnt_q + 16'd1;
                    grant_d    = 2'd0;
                    cool_cnt_d = '0;
                    state_d    = S_COOL;
                end else if (to_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    grant_d       = 2'd0;
                    cool_cnt_d    = '0;
                    state_d       = S_COOL;
                end
            end
            S_COOL: begin
                if (cool_cnt_q == COOL_LAST) state_d = S_IDLE;
                else                         cool_cnt_d = cool_cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // New requests win over the arbiter clearing the same bit.
        pending_d = (pending_q & ~clr_mask) | {req_e, req_w, req_r};

        // Abort cancels everything, including a same-cycle request.
        if (abort) begin
            state_d       = S_IDLE;
            grant_d       = 2'd0;
            pending_d     = 3'b000;
            start_r_d     = 1'b0;
            start_w_d     = 1'b0;
            start_e_d     = 1'b0;
            done_d        = 1'b0;
            err_noack_d   = 1'b0;
            err_timeout_d = 1'b0;
            op_cnt_d      = op_cnt_q;
`ifdef NF_SCHED_RR_EN
            last_d        = last_q;
`endif
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT_ACK) ||
                 (state_d == S_WAIT_DONE) || (state_d == S_COOL);
    end

    // State, counter, output and R/B# synchroniser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= 3'b000;
            grant_q       <= 2'd0;
            start_r_q     <= 1'b0;
            start_w_q     <= 1'b0;
            start_e_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_noack_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            op_cnt_q      <= 16'd0;
            ack_cnt_q     <= '0;
            to_cnt_q      <= '0;
            cool_cnt_q    <= '0;
            done_seen_q   <= 1'b0;
            rb_meta_q     <= 1'b1;
            rb_s_q        <= 1'b1;
`ifdef NF_SCHED_RR_EN
            last_q        <= 2'd3;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            start_r_q     <= start_r_d;
            start_w_q     <= start_w_d;
            start_e_q     <= start_e_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_noack_q   <= err_noack_d;
            err_timeout_q <= err_timeout_d;
            op_cnt_q      <= op_cnt_d;
            ack_cnt_q     <= ack_cnt_d;
            to_cnt_q      <= to_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            done_seen_q   <= done_seen_d;
            rb_meta_q     <= ready_busy;
            rb_s_q        <= rb_meta_q;
`ifdef NF_SCHED_RR_EN
            last_q        <= last_d;
`endif
        end
    end

    assign start_r     = start_r_q;
    assign start_w     = start_w_q;
    assign start_e     = start_e_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign pending     = pending_q;
    assign done        = done_q;
    assign err_noack   = err_noack_q;
    assign err_timeout = err_timeout_q;
    assign op_cnt      = op_cnt_q;

endmodule

// File: doc/nf_op_scheduler.md
Name: nf_op_scheduler

Overview:
Sequences the NAND flash controller's read, write and erase operations. Latches one-cycle request pulses from the MCU or debug side, picks one pending operation, and issues a single start pulse to the flash controller. It then tracks the controller state and the flash ready/busy line until the operation completes, and enforces acknowledge and completion timeouts. Sits between the request sources and the flash controller's start_r/start_w/start_e inputs, in the 24 MHz clock domain.

Parameters:
ACK_WAIT, 16, cycles allowed after a start pulse for ctrl_state to leave 0
TO_W, 24, width of the completion timeout counter
TO_MAX, 2400000, completion timeout in cycles (100 ms at 24 MHz)
GAP, 8, idle guard cycles between consecutive operations (minimum 1)

Ports:
clk  in  1  system clock (24 MHz domain)
rst  in  1  asynchronous reset, active-high
req_r  in  1  read request pulse
req_w  in  1  write request pulse
req_e  in  1  erase request pulse
abort  in  1  synchronous abort pulse
ctrl_state  in  5  flash controller state; 0 = idle
ready_busy  in  1  flash R/B#, asynchronous, 1 = ready
start_r  out  1  read start pulse to the controller
start_w  out  1  write start pulse to the controller
start_e  out  1  erase start pulse to the controller
busy  out  1  high from ISSUE through COOL
grant  out  2  operation in flight: 0 none, 1 read, 2 write, 3 erase
pending  out  3  {erase, write, read} latched requests
done  out  1  one-cycle pulse on successful completion
err_noack  out  1  one-cycle pulse when the controller fails to acknowledge
err_timeout  out  1  one-cycle pulse on completion timeout
op_cnt  out  16  count of successful completions, wraps

Behaviour:
- Reset: all outputs 0, pending 0, FSM in IDLE, counters 0, the ready_busy synchroniser flops 1.
- ready_busy passes through a 2-flop synchroniser to give rb_s. All decisions use rb_s.
- Request latching:
  - A req_x pulse sets its pending bit.
  - A repeat request for an already pending op merges into the existing bit.
  - When a set and a clear of the same bit occur in one cycle, set wins.
- IDLE: if pending is non-zero, move to ARB on the next cycle; otherwise stay.
- ARB: fixed priority erase > write > read. Load grant, clear the chosen pending bit, go to ISSUE.
- ISSUE: assert the matching start_x for exactly 1 cycle, clear the ack counter, go to WAIT_ACK.
  - Latency from a req pulse in IDLE to start_x is 3 cycles: pend, ARB, ISSUE.
- WAIT_ACK:
  - If ctrl_state != 0, go to WAIT_DONE and clear the timeout counter.
  - Else, once ACK_WAIT cycles have elapsed, pulse err_noack, set grant 0, go to COOL. The operation is dropped, not retried.
- WAIT_DONE: the timeout counter increments every cycle.
  - Completion requires ctrl_state == 0 and rb_s == 1 for 2 consecutive cycles. On completion: pulse done, increment op_cnt (wraps 0xFFFF to 0), set grant 0, go to COOL.
  - If the counter reaches TO_MAX-1 first: pulse err_timeout, set grant 0, go to COOL.
  - If completion and timeout occur in the same cycle, completion wins.
- COOL: hold for GAP cycles, then go to IDLE. Requests keep latching during COOL and every other state.
- abort: in any state, return to IDLE next cycle.
  - Clears pending and grant. No done or err pulse.
  - start_x is not asserted in that cycle.
  - abort and a req in the same cycle: abort wins and the request is lost.
- The start_x pulses are mutually exclusive; at most one is high in any cycle.
- busy = state is one of ISSUE, WAIT_ACK, WAIT_DONE, COOL.
- Reset mid-operation returns immediately to the reset values. No completion pulse is generated.

Optional Feature:
NF_SCHED_RR_EN:
- Defined: ARB uses round-robin priority. The last granted op becomes lowest priority; the order rotates read -> write -> erase -> read. The pointer resets so that read has top priority and erase is lowest.
- Undefined: fixed priority erase > write > read, and no rotation pointer is synthesised.

Test Plan:
1. Basic read: req_r pulse at cycle 0; model the controller taking ctrl_state=3 on cycle 5 and 0 on cycle 40, with ready_busy=1.
   -> start_r high only on cycle 3; grant=1 during the op; done pulses once; op_cnt=1; busy drops after GAP=8.
2. Simultaneous requests: req_r, req_w and req_e in the same cycle.
   -> Fixed priority: issue order is erase, write, read, with pending going 111 -> 011 -> 001 -> 000; three done pulses; op_cnt=3.
   -> With NF_SCHED_RR_EN: read, write, erase.
3. No acknowledge: req_e with ctrl_state held at 0.
   -> err_noack pulses 16 cycles after start_e; grant=0; no done; op_cnt unchanged.
4. Timeout: req_w, ctrl_state goes non-zero and ready_busy is held at 0 (parameter overrides TO_MAX=100, TO_W=7).
   -> err_timeout pulses 100 cycles after entering WAIT_DONE; scheduler returns to IDLE after GAP.
5. Request during an active op: req_r issued while an erase is in WAIT_DONE, plus a second req_r.
   -> pending=001 (merged); a single start_r follows COOL after the erase's done.
6. Abort and reset: abort in WAIT_DONE with pending=010 -> IDLE, pending=0, no pulses. Then rst asserted mid-WAIT_ACK -> all outputs 0 immediately and op_cnt=0.
